// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// WIDTH-bit universal register with a burst engine. One accepted request
// applies the selected operation a number of times (cnt), one per enabled
// clock, then pulses done for a single enabled cycle.
//
// Operations (mode):
//   000 hold                 100 rotate left
//   001 parallel load (din)  101 rotate right
//   010 shift left  (sin_r)  110 arithmetic shift right
//   011 shift right (sin_l)  111 clear
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, highest priority
//   en         clock enable; low freezes every register (dout, state,
//              remaining count, latches and done)
//   start      operation request, sampled only in IDLE with en=1
//   mode[2:0]  operation select, latched at acceptance
//   cnt[CW-1:0] repeat count, latched at acceptance (shift/rotate only)
//   din        parallel load data, latched at acceptance
//   sin_l      serial input entering at the MSB on right shifts (live)
//   sin_r      serial input entering at the LSB on left shifts (live)
//   dout       register contents
//   sout_l     dout[WIDTH-1]
//   sout_r     dout[0]
//   busy       burst in progress
//   done       one-cycle completion pulse
//   state_dbg  current FSM state (0 = IDLE, 1 = RUN), for observation only
//
// Handshake: a request is accepted on an enabled edge where start=1 and the
// engine is IDLE (busy=0); start is ignored at any other edge and nothing is
// queued. After acceptance busy stays high for exactly the number of enabled
// cycles in which an operation is pending, and done is high for the single
// enabled cycle after the last operation, with dout already holding the
// final value. A zero-length shift/rotate request never raises busy and
// produces done on the next cycle. Because done coincides with IDLE, a new
// start in the done cycle is accepted immediately.
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    parameter int                 CW      = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CW-1:0]    cnt,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] dout,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done,
    output logic             state_dbg
);

    // Mode encodings
    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLR   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       mode_q;   // operation captured at acceptance
    logic [WIDTH-1:0] din_q;    // load data captured at acceptance
    logic [CW-1:0]    rem;      // operations still to apply

    logic [CW-1:0]    accept_rem;
    logic [WIDTH-1:0] op_result;

    // Repeat count for a request being accepted this cycle. Hold, load and
    // clear are single-shot, so their count is forced to one; shift and
    // rotate take the requested count, which may legally be zero.
    always_comb begin
        accept_rem = cnt;
        case (mode)
            M_HOLD, M_LOAD, M_CLR: accept_rem = CW'(1);
            default:               accept_rem = cnt;
        endcase
    end

    // One application of the latched operation to the current contents.
    // Serial inputs are taken live so a stream can be fed during a burst.
    always_comb begin
        op_result = dout;
        case (mode_q)
            M_HOLD: op_result = dout;
            M_LOAD: op_result = din_q;
            M_SHL:  op_result = {dout[WIDTH-2:0], sin_r};
            M_SHR:  op_result = {sin_l, dout[WIDTH-1:1]};
            M_ROL:  op_result = {dout[WIDTH-2:0], dout[WIDTH-1]};
            M_ROR:  op_result = {dout[0], dout[WIDTH-1:1]};
            M_ASR:  op_result = {dout[WIDTH-1], dout[WIDTH-1:1]};
            M_CLR:  op_result = '0;
            default: op_result = dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Abort any burst outright; no done pulse is produced.
            state  <= IDLE;
            mode_q <= M_HOLD;
            din_q  <= '0;
            rem    <= '0;
            dout   <= RST_VAL;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (en) begin
            // done is a single enabled-cycle pulse unless re-asserted below.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        din_q  <= din;
                        rem    <= accept_rem;
                        // dout is left untouched at the acceptance edge.
                        if (accept_rem == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    dout <= op_result;
                    rem  <= rem - CW'(1);
                    if (rem == CW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sout_l    = dout[WIDTH-1];
    assign sout_r    = dout[0];
    assign state_dbg = state;

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Directed bench for univ_shift_reg (WIDTH=8, RST_VAL=8'hA5). A table of
// per-cycle input records with hand-computed expected outputs is applied one
// clock at a time; outputs are sampled 1 time unit after the rising edge.
// A hand-written sequence then covers a burst longer than WIDTH.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH) + 1;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [CW-1:0]    cnt = '0;
    logic [WIDTH-1:0] din = '0;
    logic             sin_l = 1'b0;
    logic             sin_r = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;
    logic             state_dbg;

    always #5 clk = ~clk;

    univ_shift_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .mode      (mode),
        .cnt       (cnt),
        .din       (din),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .dout      (dout),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int row,
                       input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             rst;
        logic             en;
        logic             start;
        logic [2:0]       mode;
        logic [CW-1:0]    cnt;
        logic [WIDTH-1:0] din;
        logic             sin_l;
        logic             sin_r;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_busy;
        logic             exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic e, input logic s,
                     input logic [2:0] m, input logic [CW-1:0] c,
                     input logic [WIDTH-1:0] d, input logic sl, input logic sr,
                     input logic [WIDTH-1:0] xd, input logic xb, input logic xn);
        vec_t t;
        t.rst = r; t.en = e; t.start = s; t.mode = m; t.cnt = c; t.din = d;
        t.sin_l = sl; t.sin_r = sr;
        t.exp_dout = xd; t.exp_busy = xb; t.exp_done = xn;
        vecs.push_back(t);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input vec_t t);
        rst = t.rst; en = t.en; start = t.start; mode = t.mode;
        cnt = t.cnt; din = t.din; sin_l = t.sin_l; sin_r = t.sin_r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input int row, input logic [WIDTH-1:0] xd,
                                 input logic xb, input logic xn);
        logic [WIDTH-1:0] xd_tmp;
        xd_tmp = xd;
        chk("dout",   row, dout, xd);
        chk("busy",   row, {7'b0, busy}, {7'b0, xb});
        chk("done",   row, {7'b0, done}, {7'b0, xn});
        chk("sout_l", row, {7'b0, sout_l}, {7'b0, xd_tmp[WIDTH-1]});
        chk("sout_r", row, {7'b0, sout_r}, {7'b0, xd_tmp[0]});
    endtask

    initial begin
        int busy_cycles;
        int done_seen;

        //  rst en st mode    cnt din    sl  sr   dout   busy done
        // Reset held two cycles
        v(1, 0, 0, 3'b000, 0, 8'h00, 0, 0, 8'hA5, 0, 0);
        v(1, 0, 0, 3'b000, 0, 8'h00, 0, 0, 8'hA5, 0, 0);
        // Load 3C: acceptance, then op edge, then done clears
        v(0, 1, 1, 3'b001, 0, 8'h3C, 0, 0, 8'hA5, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h3C, 0, 1);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h3C, 0, 0);
        // Load 81, then rotate left by 3
        v(0, 1, 1, 3'b001, 0, 8'h81, 0, 0, 8'h3C, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h81, 0, 1);
        v(0, 1, 1, 3'b100, 3, 8'h00, 0, 0, 8'h81, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h03, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h06, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h0C, 0, 1);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h0C, 0, 0);
        // Load 90, then arithmetic shift right by 2
        v(0, 1, 1, 3'b001, 0, 8'h90, 0, 0, 8'h0C, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h90, 0, 1);
        v(0, 1, 1, 3'b110, 2, 8'h00, 0, 0, 8'h90, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'hC8, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'hE4, 0, 1);
        // Clear, started in the done cycle (accepted); cnt ignored
        v(0, 1, 1, 3'b111, 0, 8'h00, 0, 0, 8'hE4, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        // Shift left by 4 with sin_r 1,0,1,1 and a 2-cycle stall after op 2
        v(0, 1, 1, 3'b010, 4, 8'h00, 0, 0, 8'h00, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 1, 8'h01, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h02, 1, 0);
        v(0, 0, 0, 3'b000, 0, 8'h00, 0, 1, 8'h02, 1, 0);
        v(0, 0, 0, 3'b000, 0, 8'h00, 0, 0, 8'h02, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 1, 8'h05, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 1, 8'h0B, 0, 1);
        // done frozen while en low, then clears
        v(0, 0, 0, 3'b000, 0, 8'h00, 0, 0, 8'h0B, 0, 1);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h0B, 0, 0);
        // cnt=0 shift: done next cycle, busy never high
        v(0, 1, 1, 3'b010, 0, 8'h00, 0, 1, 8'h0B, 0, 1);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 1, 8'h0B, 0, 0);
        // Shift right by 2 with sin_l 1 then 0; start during burst ignored
        v(0, 1, 1, 3'b011, 2, 8'h00, 1, 0, 8'h0B, 1, 0);
        v(0, 1, 1, 3'b001, 2, 8'hFF, 1, 0, 8'h85, 1, 0);
        v(0, 1, 1, 3'b001, 2, 8'hFF, 0, 0, 8'h42, 0, 1);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h42, 0, 0);
        // Rotate right by 1
        v(0, 1, 1, 3'b101, 1, 8'h00, 0, 0, 8'h42, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h21, 0, 1);
        // Hold mode: one busy cycle, value unchanged
        v(0, 1, 1, 3'b000, 5, 8'h00, 0, 0, 8'h21, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h21, 0, 1);
        // cnt=5 shift left, rst (with start) at the 2nd op: abort, no done
        v(0, 1, 1, 3'b010, 5, 8'h00, 0, 0, 8'h21, 1, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'h42, 1, 0);
        v(1, 1, 1, 3'b001, 0, 8'h77, 0, 0, 8'hA5, 0, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'hA5, 0, 0);
        v(0, 1, 0, 3'b000, 0, 8'h00, 0, 0, 8'hA5, 0, 0);

        // Table application
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
            check_outputs(i, vecs[i].exp_dout, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Burst longer than WIDTH: shift left 9 times with sin_r=1 from A5.
        // After 8 shifts only sin_r history remains, so the result is FF.
        rst = 0; en = 1; start = 1; mode = 3'b010; cnt = CW'(9);
        din = '0; sin_l = 0; sin_r = 1;
        step();
        start = 0; mode = 3'b000; cnt = '0;
        busy_cycles = busy ? 1 : 0;
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (busy) busy_cycles++;
            if (done) begin
                done_seen = 1;
                break;
            end
        end
        chk("long_done_seen", 100, done_seen[7:0], 8'd1);
        chk("long_dout", 100, dout, 8'hFF);
        chk("long_busy_cycles", 100, busy_cycles[7:0], 8'd9);
        step();
        chk("long_done_clear", 101, {7'b0, done}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
